load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: turns one execute-stage memory request into a fixed-latency
// DataMemory access and a single-cycle completion/write-back pulse.
module load_store_unit #(
   parameter int unsigned MEM_LATENCY = 2,
   parameter int unsigned MEM_DEPTH   = 256
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ReqValid,
   output logic        ReqReady,
   input  logic        ReqWrite,
   input  logic [15:0] ReqAddress,
   input  logic [15:0] ReqData,
   input  logic [2:0]  ReqDest,
   output logic        MemRead,
   output logic        MemWrite,
   output logic        MemtoReg,
   output logic [15:0] Address,
   output logic [15:0] WriteData,
   input  logic [15:0] outData,
   output logic        RespValid,
   output logic [15:0] RespData,
   output logic [2:0]  RespDest,
   output logic        RegWrite,
   output logic        AddrError
);

   localparam int unsigned AW = 16;
   localparam int unsigned DW = 16;
   localparam int unsigned RW = 3;
   localparam int unsigned CW = 4;

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} stateType;

   stateType        state, stateNext;
   logic [CW-1:0]   count, countNext;
   logic [RW-1:0]   latchDest, latchDestNext;

   logic            reqReadyNext;
   logic            memReadNext;
   logic            memWriteNext;
   logic            memtoRegNext;
   logic [AW-1:0]   addressNext;
   logic [DW-1:0]   writeDataNext;
   logic            respValidNext;
   logic [DW-1:0]   respDataNext;
   logic [RW-1:0]   respDestNext;
   logic            regWriteNext;
   logic            addrErrorNext;
   logic            outOfRange;

   assign outOfRange = 32'(ReqAddress) >= MEM_DEPTH;

   // Next-state and next-output decode; every output is registered below.
   always_comb begin
      stateNext     = state;
      countNext     = count;
      latchDestNext = latchDest;
      reqReadyNext  = 1'b0;
      memReadNext   = 1'b0;
      memWriteNext  = 1'b0;
      memtoRegNext  = 1'b0;
      addressNext   = Address;
      writeDataNext = WriteData;
      respValidNext = 1'b0;
      respDataNext  = RespData;
      respDestNext  = RespDest;
      regWriteNext  = 1'b0;
      addrErrorNext = 1'b0;

      case (state)
         IDLE: begin
            reqReadyNext = 1'b1;
            if (ReqValid) begin
               if (outOfRange) begin
                  addrErrorNext = 1'b1;
               end else begin
                  stateNext     = ACCESS;
                  reqReadyNext  = 1'b0;
                  countNext     = CW'(MEM_LATENCY - 1);
                  latchDestNext = ReqDest;
                  addressNext   = ReqAddress;
                  writeDataNext = ReqWrite ? ReqData : DW'(0);
                  memReadNext   = ~ReqWrite;
                  memWriteNext  = ReqWrite;
               end
            end
         end
         ACCESS: begin
            if (count == CW'(0)) begin
               // Last strobe cycle: sample load data and raise the response.
               stateNext     = RESP;
               respValidNext = 1'b1;
               respDestNext  = latchDest;
               respDataNext  = MemRead ? outData : DW'(0);
               regWriteNext  = MemRead;
               memtoRegNext  = MemRead;
            end else begin
               countNext    = count - CW'(1);
               memReadNext  = MemRead;
               memWriteNext = MemWrite;
            end
         end
         RESP: begin
            stateNext    = IDLE;
            reqReadyNext = 1'b1;
         end
         default: begin
            stateNext    = IDLE;
            reqReadyNext = 1'b1;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         count     <= '0;
         latchDest <= '0;
         ReqReady  <= 1'b1;
         MemRead   <= 1'b0;
         MemWrite  <= 1'b0;
         MemtoReg  <= 1'b0;
         Address   <= '0;
         WriteData <= '0;
         RespValid <= 1'b0;
         RespData  <= '0;
         RespDest  <= '0;
         RegWrite  <= 1'b0;
         AddrError <= 1'b0;
      end else begin
         state     <= stateNext;
         count     <= countNext;
         latchDest <= latchDestNext;
         ReqReady  <= reqReadyNext;
         MemRead   <= memReadNext;
         MemWrite  <= memWriteNext;
         MemtoReg  <= memtoRegNext;
         Address   <= addressNext;
         WriteData <= writeDataNext;
         RespValid <= respValidNext;
         RespData  <= respDataNext;
         RespDest  <= respDestNext;
         RegWrite  <= regWriteNext;
         AddrError <= addrErrorNext;
      end
   end

endmodule
